// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - pipeline stall/bubble/flush/freeze sequencer with perf counters
module hazard_stall_controller #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fw_en,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic [4:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_req,
    input  logic             br_taken,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             bubble_id_exe,
    output logic             flush_if_id,
    output logic             freeze_all,
    output logic             mem_done,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic ST_RUN  = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    // A zero latency means memory never stalls; otherwise the entry cycle
    // is the first freeze cycle, so WAIT holds for MEM_LAT-1 more.
    localparam bit         HAS_WAIT = (MEM_LAT > 0);
    localparam logic [3:0] LAT_M1   = HAS_WAIT ? 4'(MEM_LAT - 1) : 4'd0;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             state_q, state_d;
    logic [3:0]       wcnt_q, wcnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic m1_exe, m2_exe, m1_mem, m2_mem;
    logic hz;

    // Source/destination matches; register 0 never creates a dependency.
    always_comb begin
        m1_exe = (id_src1 == exe_dest) && (id_src1 != 5'd0);
        m2_exe = (id_src2 == exe_dest) && (id_src2 != 5'd0);
        m1_mem = (id_src1 == mem_dest) && (id_src1 != 5'd0);
        m2_mem = (id_src2 == mem_dest) && (id_src2 != 5'd0);
        if (fw_en) begin
            hz = exe_mem_r_en & exe_wb_en & (m1_exe | m2_exe);
        end else begin
            hz = (exe_wb_en & (m1_exe | m2_exe)) | (mem_wb_en & (m1_mem | m2_mem));
        end
    end

    // Per-cycle stage control: memory freeze beats hazard beats branch flush.
    always_comb begin
        freeze_pc     = 1'b0;
        freeze_if_id  = 1'b0;
        bubble_id_exe = 1'b0;
        flush_if_id   = 1'b0;
        freeze_all    = 1'b0;
        mem_done      = 1'b0;
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_req && HAS_WAIT) begin
                    freeze_all = 1'b1;
                    freeze_pc  = 1'b1;
                    state_d    = ST_WAIT;
                    wcnt_d     = LAT_M1;
                end else begin
                    // Only reachable with mem_req when there are no wait states.
                    mem_done = mem_req;
                    if (hz) begin
                        freeze_pc     = 1'b1;
                        freeze_if_id  = 1'b1;
                        bubble_id_exe = 1'b1;
                    end else if (br_taken) begin
                        flush_if_id = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (wcnt_q != 4'd0) begin
                    freeze_all = 1'b1;
                    freeze_pc  = 1'b1;
                    wcnt_d     = wcnt_q - 4'd1;
                end else begin
                    // Release cycle: mem_req still belongs to the finishing access.
                    mem_done = 1'b1;
                    state_d  = ST_RUN;
                    if (hz) begin
                        freeze_pc     = 1'b1;
                        freeze_if_id  = 1'b1;
                        bubble_id_exe = 1'b1;
                    end else if (br_taken) begin
                        flush_if_id = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                wcnt_d  = 4'd0;
            end
        endcase
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (freeze_pc && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
        if (flush_if_id && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + CNT_ONE;
        end
    end

    // State, wait counter and perf counters; everything else is combinational.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            wcnt_q      <= 4'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - directed self-checking bench for hazard_stall_controller
module tb_hazard_stall_controller;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             fw_en;
    logic [4:0]       id_src1, id_src2, exe_dest, mem_dest;
    logic             exe_wb_en, exe_mem_r_en, mem_wb_en, mem_req, br_taken;
    logic             freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_all, mem_done;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    hazard_stall_controller #(.MEM_LAT(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .fw_en(fw_en),
        .id_src1(id_src1), .id_src2(id_src2),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req), .br_taken(br_taken),
        .freeze_pc(freeze_pc), .freeze_if_id(freeze_if_id), .bubble_id_exe(bubble_id_exe),
        .flush_if_id(flush_if_id), .freeze_all(freeze_all), .mem_done(mem_done),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic fw, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] ed, input logic ewb, input logic eld,
                          input logic [4:0] md, input logic mwb, input logic mreq,
                          input logic br);
        fw_en = fw; id_src1 = s1; id_src2 = s2;
        exe_dest = ed; exe_wb_en = ewb; exe_mem_r_en = eld;
        mem_dest = md; mem_wb_en = mwb; mem_req = mreq; br_taken = br;
        #1;
    endtask

    // exp order: {freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_all, mem_done}
    task automatic chk_out(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {freeze_pc, freeze_if_id, bubble_id_exe, flush_if_id, freeze_all, mem_done};
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: outputs observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_out("reset_outs", 6'b000000);
        chk_cnt("reset_stall", stall_cnt, 0);
        chk_cnt("reset_flush", flush_cnt, 0);

        // 1: load-use with forwarding
        set_in(1, 5, 0, 5, 1, 1, 0, 0, 0, 0);
        chk_out("t1_loaduse", 6'b111000);
        tick();
        chk_cnt("t1_stall_after", stall_cnt, 1);
        set_in(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_out("t1_nop", 6'b000000);
        tick();
        chk_cnt("t1_stall_hold", stall_cnt, 1);

        // 2: ALU dependency with/without forwarding, r0, MEM-stage match
        do_reset();
        set_in(1, 0, 5, 5, 1, 0, 0, 0, 0, 0);
        chk_out("t2_alu_fw", 6'b000000);
        set_in(0, 0, 5, 5, 1, 0, 0, 0, 0, 0);
        chk_out("t2_alu_nofw", 6'b111000);
        set_in(0, 0, 0, 0, 1, 1, 0, 1, 0, 0);
        chk_out("t2_r0", 6'b000000);
        set_in(0, 7, 0, 3, 1, 0, 7, 1, 0, 0);
        chk_out("t2_mem_nofw", 6'b111000);
        set_in(1, 7, 0, 3, 1, 0, 7, 1, 0, 0);
        chk_out("t2_mem_fw", 6'b000000);

        // 3: hazard beats branch, then branch flushes
        do_reset();
        set_in(1, 5, 0, 5, 1, 1, 0, 0, 0, 1);
        chk_out("t3_hz_br", 6'b111000);
        tick();
        set_in(1, 5, 0, 0, 0, 0, 0, 0, 0, 1);
        chk_out("t3_br", 6'b000100);
        tick();
        chk_cnt("t3_flush", flush_cnt, 1);
        chk_cnt("t3_stall", stall_cnt, 1);

        // 4: two-cycle memory freeze holds a branch until release
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk_out("t4_frz1", 6'b100010);
        tick();
        chk_out("t4_frz2", 6'b100010);
        tick();
        chk_out("t4_release", 6'b000101);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_out("t4_idle", 6'b000000);
        chk_cnt("t4_stall", stall_cnt, 2);
        chk_cnt("t4_flush", flush_cnt, 1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk_out("t4_b2b", 6'b100010);

        // 5: reset during the second freeze cycle, then a fresh access
        do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        chk_out("t5_frz2", 6'b100010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_out("t5_after_rst", 6'b000000);
        chk_cnt("t5_stall_rst", stall_cnt, 0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk_out("t5_new_frz1", 6'b100010);
        tick();
        chk_out("t5_new_frz2", 6'b100010);
        tick();
        chk_out("t5_new_done", 6'b000001);
        tick();
        chk_cnt("t5_stall", stall_cnt, 2);

        // 6: stall counter saturates at 15
        do_reset();
        set_in(0, 3, 0, 3, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) tick();
        chk_cnt("t6_at15", stall_cnt, 15);
        for (int i = 0; i < 4; i++) tick();
        chk_cnt("t6_sat", stall_cnt, 15);
        chk_out("t6_still_stall", 6'b111000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
